physical_transmitter: RTL and testbench

//   QPSK framer/modulator: transmit-side counterpart of the physical receiver. Accepts 2-bit payload

---
 rtl/physical_transmitter_if.sv | 21 ++
 rtl/physical_transmitter.sv | 143 ++++++++++++++
 tb/tb_physical_transmitter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/physical_transmitter_if.sv
// Sample/symbol stream bundle for the QPSK transmitter: payload symbol input and {I,Q} sample output.
// The master modport is the transmitter; the slave modport is the symbol source / DAC side.
interface physical_transmitter_if;
    logic        s_valid;
    logic [1:0]  s_data;
    logic        s_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ready;
    logic        underrun;

    modport master (
        input  s_valid, s_data, out_ready,
        output s_ready, out_valid, out_data, underrun
    );

    modport slave (
        output s_valid, s_data, out_ready,
        input  s_ready, out_valid, out_data, underrun
    );
endinterface

// File: rtl/physical_transmitter.sv
// QPSK framer/modulator: 26-symbol SOF preamble + PAYLOAD_LEN payload symbols, each held SPS samples.
// Define TX_UNDERRUN_STAT_EN to add the saturating 16-bit underrun_cnt output.
module physical_transmitter #(
    parameter int SPS         = 8,
    parameter int AMP         = 1024,
    parameter int PAYLOAD_LEN = 63,
    parameter int GAP_SYMS    = 4
) (
    input  logic clk,
    input  logic rst_n,
    physical_transmitter_if.master tx
`ifdef TX_UNDERRUN_STAT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int DATA_W  = 12;
    localparam int SOF_LEN = 26;
    localparam int SYM_MAX = (PAYLOAD_LEN > SOF_LEN) ? PAYLOAD_LEN : SOF_LEN;
    localparam int CNT_W   = $clog2(SPS);
    localparam int SYM_W   = $clog2(SYM_MAX);
    localparam int GAP_W   = $clog2(GAP_SYMS + 1);

    localparam logic [SOF_LEN-1:0] SOF_I = 26'h3278428;
    localparam logic [SOF_LEN-1:0] SOF_Q = 26'h272d17d;

    typedef enum logic [1:0] {IDLE, SOF, PAYLOAD} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        sample_cnt, sample_nxt;
    logic [SYM_W-1:0]        sym_cnt, sym_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic [2*DATA_W-1:0]     data_p0, data_nxt;
    logic                    vld_p0;
    logic                    advance;
    logic                    boundary;
    logic                    take;

    // AMP fits in 12 bits signed, so the negation never overflows
    function automatic logic signed [DATA_W-1:0] level(input logic neg);
        logic signed [DATA_W-1:0] mag;
        mag = DATA_W'(AMP);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [2*DATA_W-1:0] map_sym(input logic [1:0] sym);
        return {level(sym[1]), level(sym[0])};
    endfunction

    // preamble bit set means +AMP, transmitted MSB first
    function automatic logic [2*DATA_W-1:0] sof_sym(input logic [SYM_W-1:0] k);
        logic [4:0] idx;
        idx = 5'(SOF_LEN - 1) - 5'(k);
        return map_sym({~SOF_I[idx], ~SOF_Q[idx]});
    endfunction

    assign advance  = vld_p0 & tx.out_ready;
    assign boundary = advance && (sample_cnt == CNT_W'(SPS - 1));

    always_comb begin
        state_nxt  = state;
        sample_nxt = sample_cnt;
        sym_nxt    = sym_cnt;
        gap_nxt    = gap_cnt;
        data_nxt   = data_p0;
        take       = 1'b0;
        if (boundary) begin
            sample_nxt = '0;
            unique case (state)
                IDLE: begin
                    if (gap_cnt <= GAP_W'(1) && tx.s_valid) begin
                        state_nxt = SOF;
                        sym_nxt   = '0;
                        data_nxt  = sof_sym('0);
                    end else begin
                        gap_nxt  = (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;
                        data_nxt = '0;
                    end
                end
                SOF: begin
                    if (sym_cnt == SYM_W'(SOF_LEN - 1)) begin
                        state_nxt = PAYLOAD;
                        sym_nxt   = '0;
                        take      = 1'b1;
                    end else begin
                        sym_nxt  = sym_cnt + 1'b1;
                        data_nxt = sof_sym(sym_cnt + 1'b1);
                    end
                end
                PAYLOAD: begin
                    if (sym_cnt == SYM_W'(PAYLOAD_LEN - 1)) begin
                        state_nxt = IDLE;
                        gap_nxt   = GAP_W'(GAP_SYMS);
                        data_nxt  = '0;
                    end else begin
                        sym_nxt = sym_cnt + 1'b1;
                        take    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // a missing symbol still occupies its slot as 00 so frame length is fixed
            if (take) data_nxt = map_sym(tx.s_valid ? tx.s_data : 2'b00);
        end else if (advance) begin
            sample_nxt = sample_cnt + 1'b1;
        end
    end

    // stage p0: registered sample and framing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            data_p0    <= '0;
            state      <= IDLE;
            sample_cnt <= '0;
            sym_cnt    <= '0;
            gap_cnt    <= GAP_W'(GAP_SYMS);
        end else begin
            vld_p0     <= 1'b1;
            data_p0    <= data_nxt;
            state      <= state_nxt;
            sample_cnt <= sample_nxt;
            sym_cnt    <= sym_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

    assign tx.out_valid = vld_p0;
    assign tx.out_data  = data_p0;
    assign tx.s_ready   = take;
    assign tx.underrun  = take & ~tx.s_valid;

`ifdef TX_UNDERRUN_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= '0;
        else if (tx.underrun && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_physical_transmitter.sv
// Bench for physical_transmitter: frame-level reference model of the sample stream, random data/backpressure.
// Build with TX_UNDERRUN_STAT_EN defined to also exercise underrun_cnt.
module tb_physical_transmitter;

    localparam int SPS   = 8;
    localparam int AMP   = 1024;
    localparam int PL    = 63;
    localparam int GAP   = 4;
    localparam int FRAME = (GAP + 26 + PL) * SPS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    physical_transmitter_if bus ();
`ifdef TX_UNDERRUN_STAT_EN
    logic [15:0] underrun_cnt;
`endif

    physical_transmitter #(.SPS(SPS), .AMP(AMP), .PAYLOAD_LEN(PL), .GAP_SYMS(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (bus)
`ifdef TX_UNDERRUN_STAT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] got[$];
    logic [1:0]  tab [8][PL];
    logic [25:0] sof_i = 26'h3278428;
    logic [25:0] sof_q = 26'h272d17d;
    int n_events = 0, n_acc = 0, n_und = 0;
    int ev_base = 0, frame_base = 0;
    bit rnd_ready = 1'b0;
    bit hold_pending = 1'b0;
    logic [23:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit skipped(input int fr, input int slot);
        return fr == 1 && slot >= 10 && slot <= 12;
    endfunction

    function automatic logic [11:0] lev(input bit positive);
        return positive ? 12'(AMP) : 12'(4096 - AMP);
    endfunction

    // expected k-th accepted sample of a stream starting at frame fr0 right after reset
    function automatic logic [23:0] exp_sample(input int fr0, input int k);
        int f, r, sym;
        logic [1:0] s;
        f = fr0 + k / FRAME;
        r = k % FRAME;
        if (r < GAP * SPS) return 24'h0;
        r = r - GAP * SPS;
        if (r < 26 * SPS) begin
            sym = r / SPS;
            return {lev(((sof_i >> (25 - sym)) & 26'd1) != 0), lev(((sof_q >> (25 - sym)) & 26'd1) != 0)};
        end
        sym = (r - 26 * SPS) / SPS;
        s = skipped(f, sym) ? 2'b00 : tab[f][sym];
        return {lev(s[1] == 1'b0), lev(s[0] == 1'b0)};
    endfunction

    task automatic drive_inputs();
        int rel, fr, slot;
        rel  = n_events - ev_base;
        fr   = frame_base + rel / PL;
        slot = rel % PL;
        if (fr > 7) fr = 7;
        bus.s_valid   = !skipped(fr, slot);
        bus.s_data    = tab[fr][slot];
        bus.out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic run_until_samples(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(posedge clk); #1; drive_inputs(); c++;
        end
        if (got.size() < n) check("timeout_samples", got.size(), n);
    endtask

    task automatic run_until_events(input int n, input int budget);
        int c = 0;
        while (n_events - ev_base < n && c < budget) begin
            @(posedge clk); #1; drive_inputs(); c++;
        end
        if (n_events - ev_base < n) check("timeout_events", n_events - ev_base, n);
    endtask

    task automatic compare_range(input string tag, input int lo, input int hi, input int fr0, input int k0);
        int idx;
        check({tag, "_len"}, (got.size() >= hi), 1);
        if (got.size() < hi || hi <= lo) return;
        idx = hi - 1;
        for (int i = lo; i < hi; i++) begin
            if (got[i] !== exp_sample(fr0, i - k0)) begin
                idx = i;
                break;
            end
        end
        check(tag, got[idx], exp_sample(fr0, idx - k0));
    endtask

    // handshakes are sampled half a cycle before the edge that completes them
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (hold_pending) check("hold_while_stalled", bus.out_data, prev_data);
            if (bus.out_ready) got.push_back(bus.out_data);
            hold_pending = !bus.out_ready;
            prev_data    = bus.out_data;
        end else begin
            hold_pending = 1'b0;
        end
        if (bus.s_ready) begin
            n_events++;
            if (bus.s_valid) n_acc++;
        end
        if (bus.underrun) n_und++;
    end

    initial begin
        for (int f = 0; f < 8; f++)
            for (int s = 0; s < PL; s++)
                tab[f][s] = (f == 0) ? 2'(s % 4) : 2'($urandom_range(0, 3));
        bus.s_valid   = 1'b1;
        bus.s_data    = 2'b00;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_s_ready",   bus.s_ready,   0);
        check("rst_underrun",  bus.underrun,  0);
        #1 rst_n = 1'b1;
        #1 check("release_no_valid_yet", bus.out_valid, 0);
        @(posedge clk); #1;
        check("first_edge_valid", bus.out_valid, 1);
        check("first_edge_data",  bus.out_data,  0);
        drive_inputs();

        // two frames at full rate: cycling payload, then random payload with slots 10..12 starved
        run_until_samples(2 * FRAME + GAP * SPS, 3000);
        compare_range("stream_full_rate", 0, 2 * FRAME + GAP * SPS, 0, 0);
        check("sof_sym0",   got[32],  24'h400400);
        check("sof_sym1",   got[40],  24'h400c00);
        check("pay_00",     got[240], 24'h400400);
        check("pay_01",     got[248], 24'h400c00);
        check("pay_10",     got[256], 24'hc00400);
        check("pay_11",     got[264], 24'hc00c00);
        check("underrun_slot_data", got[FRAME + 240 + 10 * SPS], 24'h400400);
        check("ready_events", n_events, 2 * PL);
        check("accepts",      n_acc,    2 * PL - 3);
        check("underruns",    n_und,    3);
`ifdef TX_UNDERRUN_STAT_EN
        check("underrun_cnt", underrun_cnt, 3);
`endif

        // three frames with 50% backpressure must give the identical accepted stream
        rnd_ready = 1'b1;
        run_until_samples(5 * FRAME + GAP * SPS, 12000);
        compare_range("stream_backpressure", 2 * FRAME + GAP * SPS, 5 * FRAME + GAP * SPS, 0, 0);
        check("bp_underruns", n_und, 3);

        // abandon frame 5 mid-payload with an asynchronous reset pulse
        rnd_ready = 1'b0;
        run_until_events(5 * PL + 20, 3000);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data",  bus.out_data,  0);
        check("midrst_s_ready",   bus.s_ready,   0);
`ifdef TX_UNDERRUN_STAT_EN
        check("midrst_underrun_cnt", underrun_cnt, 0);
`endif
        compare_range("stream_before_reset", 5 * FRAME + GAP * SPS, got.size(), 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        got.delete();
        ev_base    = n_events;
        frame_base = 6;
        drive_inputs();
        #1 check("rerelease_no_valid_yet", bus.out_valid, 0);
        @(posedge clk); #1;
        check("rerelease_valid", bus.out_valid, 1);
        drive_inputs();
        run_until_samples(GAP * SPS + 26 * SPS + 16 * SPS, 1500);
        compare_range("stream_after_reset", 0, GAP * SPS + 26 * SPS + 16 * SPS, 6, 0);
        check("events_after_reset", n_events - ev_base, ((GAP * SPS + 26 * SPS + 16 * SPS - 1) - (GAP * SPS + 26 * SPS - 1)) / SPS + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
